hazard_control_unit: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core, sitting between the ID/EX decode side and the pipeline register enables. The forwarding unit resolves EX-stage operand hazards by bypass. This block covers what bypass cannot: load-use bubbles, taken-branch flushes, and whole-pipeline freezes while data memory is busy. It is a registered FSM with Mealy outputs, so each hazard is acted on in the cycle it is detected.

---
 rtl/hazard_control_unit.sv | 127 ++++++++++++
 tb/tb_hazard_control_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use bubble, taken-branch flush and dmem-busy freeze control for the 5-stage pipeline
//   Ports: clk, arst_n (async active-low); ID sources rs1_id/rs2_id with use flags, EX rd_ex/mem_read_ex/branch_taken_ex,
//   dmem_busy; outputs pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze (Mealy, zero latency).
//   Param FLUSH_DEPTH (1..3) sets flush cycles per taken branch.
//   Macro HAZARD_PERF_CNT_EN adds stall_cnt, flush_cnt_total, freeze_cnt (32-bit, wrapping).
module hazard_control_unit #(
    parameter int FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic [4:0]  rd_ex,
    input  logic        mem_read_ex,
    input  logic        branch_taken_ex,
    input  logic        dmem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pipe_freeze
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt_total,
    output logic [31:0] freeze_cnt
`endif
);
    typedef enum logic [1:0] {RUN, BUBBLE, FLUSH, WAIT} state_t;
    state_t     state, ret_state, eff, state_nx, ret_nx;
    logic [1:0] flush_cnt, cnt_nx;
    logic       load_use;
    assign load_use = mem_read_ex && rd_ex != 5'd0 &&
                      ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
    // The cycle WAIT releases behaves exactly like the state it returns to.
    assign eff = (state == WAIT && !dmem_busy) ? ret_state : state;
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_nx    = state;
        ret_nx      = ret_state;
        cnt_nx      = flush_cnt;
        case (eff)
            RUN, BUBBLE: begin
                if (dmem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_freeze = 1'b1;
                    ret_nx      = RUN;
                    state_nx    = WAIT;
                end else if (branch_taken_ex) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    cnt_nx      = (FLUSH_DEPTH > 1) ? 2'(FLUSH_DEPTH - 1) : flush_cnt;
                    state_nx    = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
                end else if (eff == RUN && load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    state_nx    = BUBBLE;
                end else begin
                    state_nx    = RUN;
                end
            end
            FLUSH: begin
                if (dmem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_freeze = 1'b1;
                    ret_nx      = FLUSH;
                    state_nx    = WAIT;
                end else begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    cnt_nx      = flush_cnt - 2'd1;
                    state_nx    = (flush_cnt == 2'd1) ? RUN : FLUSH;
                end
            end
            WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_freeze = 1'b1;
            end
            default: state_nx = RUN;
        endcase
        // While reset is held, IF/ID and ID/EX are forced to NOPs and the PC holds.
        if (!arst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pipe_freeze = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            flush_cnt <= cnt_nx;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic stall_ev, br_ev;
    assign stall_ev = eff == RUN && !dmem_busy && !branch_taken_ex && load_use;
    assign br_ev    = (eff == RUN || eff == BUBBLE) && !dmem_busy && branch_taken_ex;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt       <= 32'd0;
            flush_cnt_total <= 32'd0;
            freeze_cnt      <= 32'd0;
        end else begin
            stall_cnt       <= stall_cnt + 32'(stall_ev);
            flush_cnt_total <= flush_cnt_total + 32'(br_ev);
            freeze_cnt      <= freeze_cnt + 32'(pipe_freeze);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: vector table, corner sequences and random checks of hazard_control_unit against a cycle model
module tb_hazard_control_unit;
    localparam int FD = 3;
    // Output vectors packed as {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}
    localparam logic [4:0] DEF = 5'b11000;
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] FL  = 5'b11110;
    localparam logic [4:0] FRZ = 5'b00001;
    localparam logic [4:0] RST = 5'b00110;
    logic       clk = 1'b0, arst_n = 1'b0;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic       rs1_used_id = 1'b0, rs2_used_id = 1'b0, mem_read_ex = 1'b0;
    logic       branch_taken_ex = 1'b0, dmem_busy = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt_total, freeze_cnt;
`endif
    hazard_control_unit #(.FLUSH_DEPTH(FD)) dut (
        .clk(clk), .arst_n(arst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt_total(flush_cnt_total), .freeze_cnt(freeze_cnt)
`endif
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    // Model: pending flush cycles, whether last cycle was a bubble, event counts
    int fl_left = 0;
    bit bub = 1'b0;
    int m_stall = 0, m_ftot = 0, m_frz = 0;
    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       mr, br, bz;
        logic [4:0] exp;
    } vec_t;
    vec_t tab[17];
    function automatic logic [4:0] got();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze};
    endfunction
    task automatic check(input string nm, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, g, e);
        end
    endtask
    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                         input logic [4:0] d, input logic mr, input logic br, input logic bz);
        rs1_id = a; rs2_id = b; rs1_used_id = ua; rs2_used_id = ub;
        rd_ex = d; mem_read_ex = mr; branch_taken_ex = br; dmem_busy = bz;
    endtask
    task automatic model_step(output logic [4:0] e);
        bit lu;
        lu = mem_read_ex && rd_ex != 0 &&
             ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        if (dmem_busy) begin
            e = FRZ; bub = 1'b0; m_frz++;
        end else if (fl_left > 0) begin
            e = FL; fl_left--; bub = 1'b0;
        end else if (branch_taken_ex) begin
            e = FL; fl_left = FD - 1; bub = 1'b0; m_ftot++;
        end else if (lu && !bub) begin
            e = STL; bub = 1'b1; m_stall++;
        end else begin
            e = DEF; bub = 1'b0;
        end
    endtask
    task automatic model_reset();
        fl_left = 0; bub = 1'b0; m_stall = 0; m_ftot = 0; m_frz = 0;
    endtask
    // Compare at the negedge, then advance past the next rising edge
    task automatic step(input string nm, input bit use_tab, input logic [4:0] te);
        logic [4:0] me;
        @(negedge clk);
        model_step(me);
        check(nm, 32'(got()), 32'(use_tab ? te : me));
        @(posedge clk);
        #1;
    endtask
`ifdef HAZARD_PERF_CNT_EN
    task automatic check_cnts(input string nm);
        check({nm, "_stall"}, stall_cnt, 32'(m_stall));
        check({nm, "_ftot"}, flush_cnt_total, 32'(m_ftot));
        check({nm, "_frz"}, freeze_cnt, 32'(m_frz));
    endtask
`endif
    initial begin
        tab[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, STL};
        tab[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, DEF};
        tab[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, DEF};
        tab[3]  = '{5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, DEF};
        tab[4]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, STL};
        tab[5]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF};
        tab[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FL};
        tab[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, FL};
        tab[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, FL};
        tab[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF};
        tab[10] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, FL};
        tab[11] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, FL};
        tab[12] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, FL};
        tab[13] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, STL};
        tab[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ};
        tab[15] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ};
        tab[16] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF};
        #1;
        check("reset_out", 32'(got()), 32'(RST));
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        model_reset();
`ifdef HAZARD_PERF_CNT_EN
        check_cnts("after_reset");
`endif
        for (int i = 0; i < 17; i++) begin
            drive(tab[i].rs1, tab[i].rs2, tab[i].u1, tab[i].u2, tab[i].rd, tab[i].mr, tab[i].br, tab[i].bz);
            step($sformatf("vec%0d", i), 1'b1, tab[i].exp);
`ifdef HAZARD_PERF_CNT_EN
            if (i == 0) check("stall_after_lu", stall_cnt, 32'd1);
            if (i == 12) check("stall_after_br_lu", stall_cnt, 32'd2);
`endif
        end
        // Busy for 4 cycles starting at the second flush cycle
        begin
`ifdef HAZARD_PERF_CNT_EN
            logic [31:0] f0;
            f0 = freeze_cnt;
`endif
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            step("mf_br", 1'b1, FL);
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 4; k++) step($sformatf("mf_frz%0d", k), 1'b1, FRZ);
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            step("mf_fl2", 1'b1, FL);
            step("mf_fl3", 1'b1, FL);
            step("mf_done", 1'b1, DEF);
`ifdef HAZARD_PERF_CNT_EN
            check("mf_freeze_cnt", freeze_cnt - f0, 32'd4);
`endif
        end
        // Reset asserted while in WAIT
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("w_frz0", 1'b1, FRZ);
        step("w_frz1", 1'b1, FRZ);
        arst_n = 1'b0;
        #1;
        check("rst_in_wait", 32'(got()), 32'(RST));
`ifdef HAZARD_PERF_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        arst_n = 1'b1;
        model_reset();
        step("post_rst_lu", 1'b1, STL);
        step("post_rst_bub", 1'b1, DEF);
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
            step("rand", 1'b0, 5'd0);
        end
`ifdef HAZARD_PERF_CNT_EN
        check_cnts("final");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
